// File: rtl/unidade_load_store.sv
// Load/store unit: byte-addressed CPU requests onto a word-addressed memory.
// Sub-word loads extract a lane; sub-word stores do read-modify-write.
module unidade_load_store #(
   parameter int PALAVRAS_LOG2 = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        requisicao,
   input  logic        escrever,
   input  logic [1:0]  tamanho,
   input  logic        com_sinal,
   input  logic [31:0] endereco,
   input  logic [31:0] dados,
   output logic [31:0] saida,
   output logic        pronto,
   output logic        erro,
   output logic        ocupado,
   output logic [31:0] mem_endereco,
   output logic [31:0] mem_dados,
   output logic        mem_escrever,
   input  logic [31:0] mem_saida
);

   localparam logic [2:0] OCIOSO   = 3'd0;
   localparam logic [2:0] LER      = 3'd1;
   localparam logic [2:0] CAPTURA  = 3'd2;
   localparam logic [2:0] ESCREVER = 3'd3;
   localparam logic [2:0] CONCLUIR = 3'd4;
   localparam logic [2:0] FALHA    = 3'd5;

   logic [2:0]  estado_q, estado_d;
   logic        escrever_q, escrever_d;
   logic [1:0]  tamanho_q, tamanho_d;
   logic        com_sinal_q, com_sinal_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] dados_q, dados_d;
   logic [31:0] saida_q, saida_d;
   logic [31:0] mem_end_q, mem_end_d;
   logic [31:0] mem_dados_q, mem_dados_d;

   logic        falha;
   logic [31:0] indice;
   logic [4:0]  desl_b;
   logic [4:0]  desl_h;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] carga;
   logic [31:0] mescla;

   assign falha = (tamanho == 2'b11)
                | ((tamanho == 2'b01) & endereco[0])
                | ((tamanho == 2'b10) & (endereco[1:0] != 2'b00));

   // Upper address bits are dropped so accesses wrap inside the memory.
   assign indice = 32'(endereco[PALAVRAS_LOG2+1:2]);

   assign desl_b = {off_q, 3'b000};
   assign desl_h = {off_q[1], 4'b0000};
   assign lane_b = mem_saida[desl_b +: 8];
   assign lane_h = mem_saida[desl_h +: 16];

   always_comb begin
      carga  = mem_saida;
      mescla = mem_saida;
      case (tamanho_q)
         2'b00: begin
            carga = {{24{com_sinal_q & lane_b[7]}}, lane_b};
            mescla[desl_b +: 8] = dados_q[7:0];
         end
         2'b01: begin
            carga = {{16{com_sinal_q & lane_h[15]}}, lane_h};
            mescla[desl_h +: 16] = dados_q[15:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      estado_d    = estado_q;
      escrever_d  = escrever_q;
      tamanho_d   = tamanho_q;
      com_sinal_d = com_sinal_q;
      off_d       = off_q;
      dados_d     = dados_q;
      saida_d     = saida_q;
      mem_end_d   = mem_end_q;
      mem_dados_d = mem_dados_q;
      case (estado_q)
         OCIOSO: begin
            if (requisicao) begin
               escrever_d  = escrever;
               tamanho_d   = tamanho;
               com_sinal_d = com_sinal;
               off_d       = endereco[1:0];
               dados_d     = dados;
               mem_end_d   = indice;
               if (falha) begin
                  estado_d = FALHA;
               end else if (!escrever) begin
                  estado_d = LER;
               end else if (tamanho == 2'b10) begin
                  mem_dados_d = dados;
                  estado_d    = ESCREVER;
               end else begin
                  estado_d = LER;
               end
            end
         end
         LER: estado_d = CAPTURA;
         CAPTURA: begin
            if (escrever_q) begin
               mem_dados_d = mescla;
               estado_d    = ESCREVER;
            end else begin
               saida_d  = carga;
               estado_d = CONCLUIR;
            end
         end
         ESCREVER: estado_d = CONCLUIR;
         CONCLUIR: estado_d = OCIOSO;
         FALHA:    estado_d = OCIOSO;
         default:  estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         escrever_q  <= 1'b0;
         tamanho_q   <= 2'b00;
         com_sinal_q <= 1'b0;
         off_q       <= 2'b00;
         dados_q     <= '0;
         saida_q     <= '0;
         mem_end_q   <= '0;
         mem_dados_q <= '0;
      end else begin
         estado_q    <= estado_d;
         escrever_q  <= escrever_d;
         tamanho_q   <= tamanho_d;
         com_sinal_q <= com_sinal_d;
         off_q       <= off_d;
         dados_q     <= dados_d;
         saida_q     <= saida_d;
         mem_end_q   <= mem_end_d;
         mem_dados_q <= mem_dados_d;
      end
   end

   assign saida        = saida_q;
   assign mem_endereco = mem_end_q;
   assign mem_dados    = mem_dados_q;
   assign ocupado      = (estado_q != OCIOSO);
   assign pronto       = (estado_q == CONCLUIR) | (estado_q == FALHA);
   assign erro         = (estado_q == FALHA);
   assign mem_escrever = (estado_q == ESCREVER);

endmodule
